// File: rtl/adf4158_pkg.sv
// Shared constants, FSM state type and shadow-index decode for the ADF4158
// configuration receiver.
package adf4158_pkg;

    localparam int unsigned FRAME_BITS  = 32;
    localparam int unsigned NUM_SHADOWS = 10;

    // Control bits [2:0] of each frame
    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // Shadow register file slots; R5 and R6 each hold two banks
    localparam logic [3:0] IDX_R0  = 4'd0;
    localparam logic [3:0] IDX_R1  = 4'd1;
    localparam logic [3:0] IDX_R2  = 4'd2;
    localparam logic [3:0] IDX_R3  = 4'd3;
    localparam logic [3:0] IDX_R4  = 4'd4;
    localparam logic [3:0] IDX_R5A = 4'd5;
    localparam logic [3:0] IDX_R5B = 4'd6;
    localparam logic [3:0] IDX_R6A = 4'd7;
    localparam logic [3:0] IDX_R6B = 4'd8;
    localparam logic [3:0] IDX_R7  = 4'd9;

    // Field positions
    localparam int unsigned RAMP_EN_BIT  = 31;
    localparam int unsigned PART_SEL_BIT = 23;
    localparam int unsigned INT_MSB      = 26;
    localparam int unsigned INT_LSB      = 15;
    localparam int unsigned FRAC_HI_MSB  = 14;
    localparam int unsigned FRAC_HI_LSB  = 3;
    localparam int unsigned FRAC_LO_MSB  = 27;
    localparam int unsigned FRAC_LO_LSB  = 15;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } rx_state_e;

    // Map control bits and the R5/R6 part-select bit onto a shadow slot.
    function automatic logic [3:0] shadow_idx(input logic [2:0] ctrl, input logic part_sel);
        logic [3:0] idx;
        idx = IDX_R0;
        case (ctrl)
            R0: idx = IDX_R0;
            R1: idx = IDX_R1;
            R2: idx = IDX_R2;
            R3: idx = IDX_R3;
            R4: idx = IDX_R4;
            R5: idx = part_sel ? IDX_R5B : IDX_R5A;
            R6: idx = part_sel ? IDX_R6B : IDX_R6A;
            R7: idx = IDX_R7;
            default: idx = IDX_R0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/adf4158_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection
// on the synchronized level.
module adf4158_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the pin into the chain and remember the previous synced level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Chain flops; reset flushes to the pin's idle level so no edge fires
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/adf4158_cfg_rx.sv
// ADF4158 3-wire configuration receiver: oversamples CLK/DATA/LE, assembles
// 32-bit frames and commits them to a 10-entry shadow register file.
// Optional feature macro: ADF4158_RX_SEQ_CHECK_EN (init-order checker on seq_err).
module adf4158_cfg_rx
    import adf4158_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        sclk,
    input  logic        sdata,
    input  logic        le,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [3:0]  word_idx,
    output logic        frame_err,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        ramp_en,
    output logic [36:0] freq_word,
    output logic        seq_err
);

    localparam logic [5:0] FULL_COUNT = 6'(FRAME_BITS);
    localparam logic [5:0] SAT_COUNT  = 6'(FRAME_BITS + 1);

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic sdata_s, sdata_rise, sdata_fall;
    logic le_rise, le_fall, le_lvl;

    adf4158_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sclk),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    adf4158_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sdata),
        .level_o(sdata_s),
        .rise_o (sdata_rise),
        .fall_o (sdata_fall)
    );

    adf4158_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (le),
        .level_o(le_lvl),
        .rise_o (le_rise),
        .fall_o (le_fall)
    );

    logic unused_pin_info;
    assign unused_pin_info = ^{sclk_lvl, sclk_fall, sdata_rise, sdata_fall, le_lvl};

    rx_state_e   state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  word_idx_q, word_idx_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] shadow_q [NUM_SHADOWS];
    logic [31:0] shadow_d [NUM_SHADOWS];

    logic       in_commit, commit_ok, commit_bad;
    logic [3:0] commit_idx;

    assign in_commit  = (state_q == StCommit) && ce;
    assign commit_ok  = in_commit && (count_q == FULL_COUNT);
    assign commit_bad = in_commit && (count_q != FULL_COUNT);
    assign commit_idx = shadow_idx(shreg_q[2:0], shreg_q[PART_SEL_BIT]);

    // Frame FSM, shift register, bit counter and shadow write
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        shadow_d   = shadow_q;
        unique case (state_q)
            StIdle: begin
                if (ce && le_fall) begin
                    count_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!ce) begin
                    state_d = StIdle;
                end else begin
                    // Shift before commit so a coincident sclk rise is counted
                    if (sclk_rise) begin
                        shreg_d = {shreg_q[30:0], sdata_s};
                        count_d = (count_q == SAT_COUNT) ? count_q : count_q + 6'd1;
                    end
                    if (le_rise) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (commit_ok) begin
                    shadow_d[commit_idx] = shreg_q;
                    word_d               = shreg_q;
                    word_idx_d           = commit_idx;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered shadow read; a same-cycle write is seen on the next read
    always_comb begin
        rd_data_d = '0;
        if (rd_addr < 4'(NUM_SHADOWS)) begin
            rd_data_d = shadow_q[rd_addr];
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < int'(NUM_SHADOWS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            rd_data_q  <= rd_data_d;
            shadow_q   <= shadow_d;
        end
    end

    // During the commit pulse the frame is presented straight from the shifter
    assign word_valid = commit_ok;
    assign frame_err  = commit_bad;
    assign word       = commit_ok ? shreg_q : word_q;
    assign word_idx   = commit_ok ? commit_idx : word_idx_q;
    assign rd_data    = rd_data_q;
    assign ramp_en    = shadow_q[IDX_R0][RAMP_EN_BIT];
    assign freq_word  = {shadow_q[IDX_R0][INT_MSB:INT_LSB],
                         shadow_q[IDX_R0][FRAC_HI_MSB:FRAC_HI_LSB],
                         shadow_q[IDX_R1][FRAC_LO_MSB:FRAC_LO_LSB]};

`ifdef ADF4158_RX_SEQ_CHECK_EN
    logic       seq_err_q, seq_err_d;
    logic       seq_done_q, seq_done_d;
    logic [3:0] seq_exp_q, seq_exp_d;

    // Init-order tracker: expects 9 down to 0; an R7 commit restarts it
    always_comb begin
        seq_err_d  = seq_err_q;
        seq_done_d = seq_done_q;
        seq_exp_d  = seq_exp_q;
        if (commit_ok) begin
            if (commit_idx == IDX_R7) begin
                seq_exp_d  = IDX_R6B;
                seq_done_d = 1'b0;
            end else if (!seq_done_q) begin
                if (commit_idx != seq_exp_q) begin
                    seq_err_d = 1'b1;
                end else begin
                    seq_exp_d = seq_exp_q - 4'd1;
                end
                if (commit_idx == IDX_R0) begin
                    seq_done_d = 1'b1;
                end
            end
        end
    end

    // Tracker registers; seq_err is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err_q  <= 1'b0;
            seq_done_q <= 1'b0;
            seq_exp_q  <= IDX_R7;
        end else begin
            seq_err_q  <= seq_err_d;
            seq_done_q <= seq_done_d;
            seq_exp_q  <= seq_exp_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_adf4158_cfg_rx.sv
// Self-checking bench for adf4158_cfg_rx: directed and random frames checked
// every cycle against an event-queue model of the shadow register file.
module tb_adf4158_cfg_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        sclk = 1'b0;
    logic        sdata = 1'b0;
    logic        le = 1'b1;
    logic [3:0]  rd_addr = 4'd0;
    logic        word_valid;
    logic [31:0] word;
    logic [3:0]  word_idx;
    logic        frame_err;
    logic [31:0] rd_data;
    logic        ramp_en;
    logic [36:0] freq_word;
    logic        seq_err;

    adf4158_cfg_rx #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .sclk      (sclk),
        .sdata     (sdata),
        .le        (le),
        .word_valid(word_valid),
        .word      (word),
        .word_idx  (word_idx),
        .frame_err (frame_err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ramp_en   (ramp_en),
        .freq_word (freq_word),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        bit          ok;
        logic [31:0] w;
        logic [3:0]  idx;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev;
    logic [31:0] m_sh [10];
    logic [31:0] m_word = 32'd0;
    logic [3:0]  m_idx = 4'd0;
    logic [31:0] m_rd = 32'd0;
    int          valid_pulses = 0;
    int          err_pulses = 0;
    bit          exp_v, exp_e;
    logic [31:0] exp_w;
    logic [3:0]  exp_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Slot a frame lands in, straight from the register map
    function automatic logic [3:0] ref_idx(input logic [31:0] w);
        logic [2:0] c;
        c = w[2:0];
        case (c)
            3'd5: return w[23] ? 4'd6 : 4'd5;
            3'd6: return w[23] ? 4'd8 : 4'd7;
            3'd7: return 4'd9;
            default: return {1'b0, c};
        endcase
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            evq.delete();
            for (int i = 0; i < 10; i++) m_sh[i] = 32'd0;
            m_word = 32'd0;
            m_idx  = 4'd0;
            m_rd   = 32'd0;
        end else begin
            exp_v = 1'b0;
            exp_e = 1'b0;
            exp_w = m_word;
            exp_i = m_idx;
            if (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("commit_missed", 64'(cyc), 64'(evq[0].cyc));
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev    = evq.pop_front();
                exp_v = ev.ok;
                exp_e = !ev.ok;
                if (ev.ok) begin
                    exp_w = ev.w;
                    exp_i = ev.idx;
                end
            end
            chk("word_valid", 64'(word_valid), 64'(exp_v));
            chk("frame_err", 64'(frame_err), 64'(exp_e));
            chk("word", 64'(word), 64'(exp_w));
            chk("word_idx", 64'(word_idx), 64'(exp_i));
            chk("ramp_en", 64'(ramp_en), 64'(m_sh[0][31]));
            chk("freq_word", 64'(freq_word), 64'({m_sh[0][26:15], m_sh[0][14:3], m_sh[1][27:15]}));
            chk("rd_data", 64'(rd_data), 64'(m_rd));
`ifndef ADF4158_RX_SEQ_CHECK_EN
            chk("seq_err_tied", 64'(seq_err), 64'd0);
`endif
            if (word_valid === 1'b1) valid_pulses++;
            if (frame_err === 1'b1) err_pulses++;
            m_rd = (rd_addr < 4'd10) ? m_sh[rd_addr] : 32'd0;
            if (exp_v) begin
                m_sh[exp_i] = exp_w;
                m_word      = exp_w;
                m_idx       = exp_i;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] w, input int nbits);
        ev_t e;
        e.cyc = cyc + 3;
        e.ok  = (nbits == 32);
        e.w   = w;
        e.idx = ref_idx(w);
        evq.push_back(e);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        le   = 1'b1;
        sclk = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
    endtask

    // One LE-framed transfer at clk/4; optional abort by ce drop or reset
    task automatic send_frame(input logic [31:0] w, input int nbits, input bit same_edge,
                              input int abort_at, input bit abort_rst);
        le = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                if (abort_rst) begin
                    rst  = 1'b1;
                    le   = 1'b1;
                    sclk = 1'b0;
                    tick(4);
                    rst = 1'b0;
                    tick(4);
                end else begin
                    ce = 1'b0;
                    tick(3);
                    le   = 1'b1;
                    sclk = 1'b0;
                    tick(6);
                    ce = 1'b1;
                    tick(4);
                end
                return;
            end
            sdata = (i < 32) ? w[31-i] : 1'($urandom);
            sclk  = 1'b0;
            tick(2);
            if (same_edge && i == nbits - 1) begin
                sclk = 1'b1;
                le   = 1'b1;
                push(w, nbits);
                tick(2);
                sclk = 1'b0;
                tick(8);
                return;
            end
            sclk = 1'b1;
            tick(2);
        end
        sclk = 1'b0;
        tick(2);
        le = 1'b1;
        push(w, nbits);
        tick(10);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        rd_addr = a;
        tick(1);
        chk(name, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, nb, mode, ab;
        bit se;
        logic [31:0] w;

        do_reset();
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        chk("rst_word_idx", 64'(word_idx), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_freq_word", 64'(freq_word), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);

        // R0 = 0x30848000: INT field 265, ramp off
        v0 = valid_pulses;
        send_frame(32'h30848000, 32, 1'b0, -1, 1'b0);
        chk("r0_pulses", 64'(valid_pulses - v0), 64'd1);
        chk("r0_idx", 64'(word_idx), 64'd0);
        chk("r0_word", 64'(word), 64'h30848000);
        chk("r0_int", 64'(freq_word[36:25]), 64'd265);
        chk("r0_ramp", 64'(ramp_en), 64'd0);

        // R5 with part-select set lands in slot 6 only
        send_frame(32'h00800005, 32, 1'b0, -1, 1'b0);
        chk("r5b_idx", 64'(word_idx), 64'd6);
        rd_chk("r5b_rd6", 4'd6, 32'h00800005);
        rd_chk("r5a_rd5", 4'd5, 32'h0);
        rd_chk("rd_oob", 4'd12, 32'h0);

        // Short and long frames: two errors, no commits
        v0 = valid_pulses;
        e0 = err_pulses;
        send_frame(32'hFFFFFFF9, 31, 1'b0, -1, 1'b0);
        send_frame(32'hFFFFFFF9, 33, 1'b0, -1, 1'b0);
        chk("err_pulses", 64'(err_pulses - e0), 64'd2);
        chk("err_no_commit", 64'(valid_pulses - v0), 64'd0);
        rd_chk("err_r0_kept", 4'd0, 32'h30848000);

        // ce drop mid-frame, then a clean R2
        v0 = valid_pulses;
        send_frame(32'hFFFF0002, 32, 1'b0, 16, 1'b0);
        send_frame(32'h0A5C3E12, 32, 1'b0, -1, 1'b0);
        chk("ce_pulses", 64'(valid_pulses - v0), 64'd1);
        chk("ce_r2_word", 64'(word), 64'h0A5C3E12);
        chk("ce_r2_idx", 64'(word_idx), 64'd2);
        rd_chk("ce_r2_rd", 4'd2, 32'h0A5C3E12);

        // Shift and latch on the same edge still make a full frame
        send_frame(32'h12345673, 32, 1'b1, -1, 1'b0);
        chk("same_edge_idx", 64'(word_idx), 64'd3);

        // R0 commit, then reset during R1
        send_frame(32'h80048008, 32, 1'b0, -1, 1'b0);
        chk("r0b_ramp", 64'(ramp_en), 64'd1);
        v0 = valid_pulses;
        send_frame(32'h0FFF8001, 32, 1'b0, 16, 1'b1);
        chk("rst_no_pulse", 64'(valid_pulses - v0), 64'd0);
        for (int a = 0; a < 10; a++) rd_chk("rst_shadow", 4'(a), 32'h0);

        // Random frames
        for (int n = 0; n < 40; n++) begin
            w    = $urandom;
            mode = $urandom_range(0, 9);
            nb   = (mode < 7) ? 32 : $urandom_range(0, 40);
            se   = ($urandom_range(0, 3) == 0) && (nb > 0);
            ab   = (mode == 9 && nb > 0) ? $urandom_range(0, nb - 1) : -1;
            rd_addr = 4'($urandom_range(0, 15));
            send_frame(w, nb, se, ab, 1'($urandom_range(0, 1)));
        end

`ifdef ADF4158_RX_SEQ_CHECK_EN
        do_reset();
        send_frame(32'h00000007, 32, 1'b0, -1, 1'b0);
        send_frame(32'h00800006, 32, 1'b0, -1, 1'b0);
        send_frame(32'h00000006, 32, 1'b0, -1, 1'b0);
        send_frame(32'h00800005, 32, 1'b0, -1, 1'b0);
        send_frame(32'h00000005, 32, 1'b0, -1, 1'b0);
        for (int r = 4; r >= 0; r--) send_frame(32'h00100000 | 32'(r), 32, 1'b0, -1, 1'b0);
        chk("seq_ok", 64'(seq_err), 64'd0);
        send_frame(32'h00000007, 32, 1'b0, -1, 1'b0);
        send_frame(32'h00000004, 32, 1'b0, -1, 1'b0);
        chk("seq_bad", 64'(seq_err), 64'd1);
        send_frame(32'h00000000, 32, 1'b0, -1, 1'b0);
        chk("seq_sticky", 64'(seq_err), 64'd1);
`else
        chk("seq_off", 64'(seq_err), 64'd0);
`endif

        tick(10);
        chk("events_drained", 64'(evq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
